pc_trace_uart: RTL and testbench
================================

Name: pc_trace_uart

Overview:
- Downstream consumer of the processor top's 8-bit `display` output, which carries the low byte of the stage-1a fetch address.
- Samples that byte every clock and queues changed values in a small synchronous FIFO.
- Serialises the queued bytes out of a UART transmitter pin (8N1) so a board can stream a live PC trace to a host.
- Sits beside the processor top in the board wrapper and shares its clock and reset.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (≥2).
- FIFO_DEPTH, 16, trace FIFO entries; power of two, ≥2.
- CHANGE_ONLY, 1, 1 = enqueue only when the sample differs from the previous sample; 0 = enqueue every enabled cycle.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- display_in  in  8  byte from the processor top's `display`.
- enable  in  1  sampling enable; 0 = no enqueues, transmission continues.
- tx  out  1  UART serial output, idle high.
- busy  out  1  transmitter not in IDLE.
- overflow  out  1  sticky; set when an enqueue is dropped.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset state (reset==0 at an edge): tx=1, busy=0, overflow=0, fifo_count=0, FIFO flushed, prev_valid=0, FSM=IDLE. Reset mid-frame aborts the frame; tx is high from that edge onward.
- Push condition: enable && (!CHANGE_ONLY || !prev_valid || display_in != prev).
  - prev and prev_valid update on every enabled cycle.
  - The first enabled sample after reset is always pushed.
- FIFO push/pop rules:
  - A push is accepted if count<DEPTH, or if a pop happens on the same edge (the pop frees the slot first).
  - Otherwise the push is dropped and overflow←1. overflow clears only on reset.
  - Simultaneous push and pop leaves count unchanged.
  - Read and write pointers wrap modulo DEPTH.
- Transmitter FSM: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is non-empty, pop, load the shift register, go to START. tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, CLKS_PER_BIT cycles each; the bit index counts 0..7, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Bit timer: loads CLKS_PER_BIT-1 on every state or bit entry and counts down to 0.
- busy = (state != IDLE).
- Latency: a value pushed at edge E0 into an empty FIFO with FSM in IDLE is popped at E1, and tx goes low after E1. One frame lasts 10×CLKS_PER_BIT cycles.
- tx is registered (no glitches).

Optional Feature:
- Macro: TRACE_ASCII_HEX_EN.
- Defined: each FIFO entry is sent as three frames: the ASCII hex upper nibble, the ASCII hex lower nibble, then 0x0A.
  - Nibble mapping: 0–9 → 0x30–0x39; A–F → 0x41–0x46 (uppercase).
  - The entry is popped once, at the start of the first character, and held in an entry register.
  - A character index 0..2 sequences STOP back to START without popping until index 2 completes.
- Undefined: one raw binary frame per entry, and no entry register or character index exists.

Decomposition:
- Package trace_pkg holds:
  - the tx_state_t enum {IDLE, START, DATA, STOP};
  - constants ASCII_0=8'h30, ASCII_A=8'h41, ASCII_LF=8'h0A;
  - function hex_ascii(logic [3:0]) → logic [7:0].
- Sub-module trace_fifo: parameterised synchronous FIFO with push, pop, din, dout, count, full and empty. dout is valid combinationally from the read pointer.

Test Plan (CLKS_PER_BIT=4 unless noted):
- Reset: hold reset=0 for 3 cycles with toggling display_in → tx=1, busy=0, overflow=0, fifo_count=0 throughout.
- Single byte: enable=1, display_in 0xA5 after reset → tx low after the second edge for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high for 4 cycles. busy falls 40 cycles after the pop.
- Change-only: display_in held at 0x3C for 200 cycles → exactly one frame (0x3C). Then change to 0x3D → exactly one more frame.
- Overflow with FIFO_DEPTH=4: distinct values v0..v5 on six consecutive edges →
  - v0 is popped at E1 and v5 is dropped;
  - overflow=1 from E5;
  - frames v0,v1,v2,v3,v4 follow back-to-back with no idle gap.
- Reset mid-frame: assert reset during DATA bit 3 → tx=1 and busy=0 at that edge, fifo_count=0. After release the next sample retransmits (prev_valid cleared).
- With TRACE_ASCII_HEX_EN defined: display 0xA5 → frames 0x41, 0x35, 0x0A back-to-back, taking 120 cycles total.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types, constants and helpers for the PC trace UART.
package trace_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_A  = 8'h41;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return ASCII_0 + {4'h0, nib};
        else
            return ASCII_A + {4'h0, nib} - 8'd10;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted when a pop frees the slot on the same edge.
module trace_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == ($clog2(DEPTH+1))'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr];

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !rd_en)
                count <= count + 1'b1;
            else if (rd_en && !wr_en)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pc_trace_uart.sv
// Samples the processor display byte, queues changes and streams them out as 8N1 UART frames.
// Define TRACE_ASCII_HEX_EN to send each entry as two ASCII hex digits plus a line feed.
module pc_trace_uart
    import trace_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16,
    parameter bit CHANGE_ONLY  = 1'b1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [7:0]                      display_in,
    input  logic                            enable,
    output logic                            tx,
    output logic                            busy,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
    localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] T_LOAD = TW'(CLKS_PER_BIT - 1);

    tx_state_t     state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shreg, shreg_n;
    logic          tx_n;
    logic [7:0]    prev;
    logic          prev_valid;
    logic          push, pop, full, empty;
    logic [7:0]    dout;
`ifdef TRACE_ASCII_HEX_EN
    logic [7:0]    entry, entry_n;
    logic [1:0]    char_idx, char_idx_n;
`endif

    assign push = enable && (!CHANGE_ONLY || !prev_valid || (display_in != prev));
    assign busy = (state != IDLE);

    trace_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (display_in),
        .dout  (dout),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_n   = state;
        timer_n   = timer;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        pop       = 1'b0;
`ifdef TRACE_ASCII_HEX_EN
        entry_n    = entry;
        char_idx_n = char_idx;
`endif
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = START;
                    timer_n = T_LOAD;
`ifdef TRACE_ASCII_HEX_EN
                    entry_n    = dout;
                    char_idx_n = 2'd0;
                    shreg_n    = hex_ascii(dout[7:4]);
`else
                    shreg_n    = dout;
`endif
                end
            end
            START: begin
                if (timer == '0) begin
                    state_n   = DATA;
                    timer_n   = T_LOAD;
                    bit_idx_n = 3'd0;
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            DATA: begin
                if (timer == '0) begin
                    timer_n = T_LOAD;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shreg_n   = {1'b0, shreg[7:1]};
                    end
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            STOP: begin
                if (timer == '0) begin
`ifdef TRACE_ASCII_HEX_EN
                    // Remaining characters of the held entry go out without touching the FIFO.
                    if (char_idx != 2'd2) begin
                        char_idx_n = char_idx + 2'd1;
                        shreg_n    = (char_idx == 2'd0) ? hex_ascii(entry[3:0]) : ASCII_LF;
                        state_n    = START;
                        timer_n    = T_LOAD;
                    end else if (!empty) begin
                        pop        = 1'b1;
                        entry_n    = dout;
                        char_idx_n = 2'd0;
                        shreg_n    = hex_ascii(dout[7:4]);
                        state_n    = START;
                        timer_n    = T_LOAD;
                    end else begin
                        state_n = IDLE;
                    end
`else
                    if (!empty) begin
                        pop     = 1'b1;
                        shreg_n = dout;
                        state_n = START;
                        timer_n = T_LOAD;
                    end else begin
                        state_n = IDLE;
                    end
`endif
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // Registered tx follows the state being entered, so it never glitches.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shreg_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            timer      <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            tx         <= 1'b1;
            prev       <= '0;
            prev_valid <= 1'b0;
            overflow   <= 1'b0;
`ifdef TRACE_ASCII_HEX_EN
            entry      <= '0;
            char_idx   <= '0;
`endif
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            tx      <= tx_n;
            if (enable) begin
                prev       <= display_in;
                prev_valid <= 1'b1;
            end
            if (push && full && !pop)
                overflow <= 1'b1;
`ifdef TRACE_ASCII_HEX_EN
            entry    <= entry_n;
            char_idx <= char_idx_n;
`endif
        end
    end

endmodule

// File: tb/tb_pc_trace_uart.sv
// Directed self-checking bench for pc_trace_uart (CLKS_PER_BIT=4, FIFO_DEPTH=4).
module tb_pc_trace_uart;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] display_in = 8'h00;
    logic       enable = 1'b0;
    logic       tx, busy, overflow;
    logic [2:0] fifo_count;

    int checks   = 0;
    int failures = 0;
    int low_seen;

    pc_trace_uart #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .CHANGE_ONLY(1'b1)) dut (
        .clock      (clock),
        .reset      (reset),
        .display_in (display_in),
        .enable     (enable),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] asc(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Called just after the edge that starts a frame; checks tx each cycle for 40 cycles.
    task automatic expect_frame(input logic [7:0] b, input int skip);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int k = skip; k < 40; k++) begin
            check("frame_bit", {31'b0, tx}, {31'b0, f[k/4]});
            tick();
        end
    endtask

    task automatic send_entry(input logic [7:0] v, input int skip);
`ifdef TRACE_ASCII_HEX_EN
        expect_frame(asc(v[7:4]), skip);
        expect_frame(asc(v[3:0]), 0);
        expect_frame(8'h0A, 0);
`else
        expect_frame(v, skip);
`endif
    endtask

    initial begin
        // Reset held with toggling input.
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            display_in = 8'h10 + 8'(i);
            tick();
            check("rst_tx", {31'b0, tx}, 32'd1);
            check("rst_busy", {31'b0, busy}, 32'd0);
            check("rst_ovf", {31'b0, overflow}, 32'd0);
            check("rst_count", {29'b0, fifo_count}, 32'd0);
        end

        // Single byte 0xA5.
        reset = 1'b1;
        display_in = 8'hA5;
        tick();
        check("e0_count", {29'b0, fifo_count}, 32'd1);
        check("e0_busy", {31'b0, busy}, 32'd0);
        check("e0_tx", {31'b0, tx}, 32'd1);
        tick();
        check("e1_count", {29'b0, fifo_count}, 32'd0);
        check("e1_busy", {31'b0, busy}, 32'd1);
        send_entry(8'hA5, 0);
        check("a5_done_busy", {31'b0, busy}, 32'd0);
        check("a5_done_tx", {31'b0, tx}, 32'd1);

        // Change-only: held value sends once.
        display_in = 8'h3C;
        tick();
        tick();
        send_entry(8'h3C, 0);
        low_seen = 0;
        for (int i = 0; i < 150; i++) begin
            if (tx == 1'b0 || busy == 1'b1) low_seen++;
            tick();
        end
        check("hold_no_refire", low_seen, 32'd0);
        display_in = 8'h3D;
        tick();
        tick();
        send_entry(8'h3D, 0);
        check("3d_done_busy", {31'b0, busy}, 32'd0);

        // Overflow with six values on consecutive edges.
        display_in = 8'h11; tick();
        check("ov_e0_count", {29'b0, fifo_count}, 32'd1);
        display_in = 8'h22; tick();
        check("ov_e1_count", {29'b0, fifo_count}, 32'd1);
        display_in = 8'h33; tick();
        display_in = 8'h44; tick();
        display_in = 8'h55; tick();
        check("ov_e4_ovf", {31'b0, overflow}, 32'd0);
        check("ov_e4_count", {29'b0, fifo_count}, 32'd4);
        display_in = 8'h66; tick();
        check("ov_e5_ovf", {31'b0, overflow}, 32'd1);
        check("ov_e5_count", {29'b0, fifo_count}, 32'd4);
        enable = 1'b0;
        send_entry(8'h11, 4);
        send_entry(8'h22, 0);
        send_entry(8'h33, 0);
        send_entry(8'h44, 0);
        send_entry(8'h55, 0);
        check("ov_done_busy", {31'b0, busy}, 32'd0);
        check("ov_done_count", {29'b0, fifo_count}, 32'd0);
        check("ov_sticky", {31'b0, overflow}, 32'd1);

        // Reset during DATA bit 3.
        enable = 1'b1;
        display_in = 8'h77;
        tick();
        tick();
        for (int i = 0; i < 17; i++) tick();
        check("mid_busy", {31'b0, busy}, 32'd1);
        reset = 1'b0;
        tick();
        check("mr_tx", {31'b0, tx}, 32'd1);
        check("mr_busy", {31'b0, busy}, 32'd0);
        check("mr_count", {29'b0, fifo_count}, 32'd0);
        check("mr_ovf", {31'b0, overflow}, 32'd0);
        reset = 1'b1;
        tick();
        check("mr_repush", {29'b0, fifo_count}, 32'd1);
        tick();
        check("mr_busy2", {31'b0, busy}, 32'd1);
        send_entry(8'h77, 0);
        check("mr_done_busy", {31'b0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
